// File: rtl/core_dma_pkg.sv
// Shared types and constants for the multi-channel bus-cycle DMA controller.
package core_dma_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_e;

    typedef enum logic {
        MODE_BLOCK  = 1'b0,
        MODE_SINGLE = 1'b1
    } dma_mode_e;

    localparam logic [15:0] DST_ADDR_DEFAULT = 16'h2004;
    localparam logic [15:0] IDLE_ADDR        = 16'h0000;

endpackage

// File: rtl/core_dma_arbiter.sv
// Fixed-priority arbiter: the lowest-index requesting channel wins.
module core_dma_arbiter #(
    parameter int CH_COUNT = 2
) (
    input  logic [CH_COUNT-1:0] req_i,
    output logic [CH_COUNT-1:0] grant_o,
    output logic                valid_o
);

    logic found_s;

    // Scan upward, granting the first set bit and masking all above it.
    always_comb begin
        grant_o = '0;
        found_s = 1'b0;
        for (int i = 0; i < CH_COUNT; i++) begin
            grant_o[i] = req_i[i] & ~found_s;
            found_s    = found_s | req_i[i];
        end
        valid_o = found_s;
    end

endmodule

// File: rtl/core_dma_mc.sv
// Multi-channel DMA controller stealing CPU bus cycles: block copy to a fixed
// destination or single-byte fetch, with per-channel resumable byte index.
module core_dma_mc
    import core_dma_pkg::*;
#(
    parameter int          CH_COUNT = 2,
    parameter int          LEN_W    = 8,
    parameter logic [15:0] DST_ADDR = DST_ADDR_DEFAULT
) (
    input  logic                      I_clock,
    input  logic                      I_reset,
    input  logic                      I_tick,
    input  logic                      I_sync,
    output logic [15:0]               O_addr,
    output logic                      O_rdwr,
    input  logic [7:0]                I_data,
    output logic [7:0]                O_data,
    input  logic [CH_COUNT-1:0]       I_req,
    input  logic [CH_COUNT-1:0]       I_mode,
    input  logic [CH_COUNT*16-1:0]    I_src,
    input  logic [CH_COUNT*LEN_W-1:0] I_len,
    output logic [CH_COUNT-1:0]       O_ack,
    output logic                      O_ready
);

    localparam int CH_W = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;
    localparam logic [LEN_W-1:0] IDX_ONE = LEN_W'(1'b1);

    dma_state_e          state_q, state_d;
    logic [CH_COUNT-1:0] pending_q, pending_d;
    logic [15:0]         src_q  [CH_COUNT];
    logic [LEN_W-1:0]    len_q  [CH_COUNT];
    dma_mode_e           mode_q [CH_COUNT];
    logic [LEN_W-1:0]    idx_q  [CH_COUNT];
    logic [LEN_W-1:0]    idx_d  [CH_COUNT];
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [15:0]         addr_q, addr_d;
    logic                rdwr_q, rdwr_d;
    logic [7:0]          data_q, data_d;
    logic [CH_COUNT-1:0] ack_q, ack_d;
    logic                ready_q, ready_d;

    logic [CH_COUNT-1:0] capture_s;
    logic [CH_COUNT-1:0] clear_s;
    logic [CH_COUNT-1:0] cur_oh_s;
    logic [CH_COUNT-1:0] others_s;
    logic [CH_COUNT-1:0] arb_req_s;
    logic [CH_COUNT-1:0] grant_s;
    logic                grant_valid_s;
    logic [CH_W-1:0]     grant_idx_s;
    logic [LEN_W-1:0]    idx_inc_s;
    logic                last_byte_s;

    // Current-channel decode, byte-index increment and arbiter request select.
    always_comb begin
        for (int i = 0; i < CH_COUNT; i++) begin
            cur_oh_s[i] = (ch_q == CH_W'(i));
        end
        others_s    = pending_q & ~cur_oh_s;
        capture_s   = I_req & ~pending_q;
        idx_inc_s   = idx_q[ch_q] + IDX_ONE;
        // A len of zero wraps the LEN_W-bit index back to zero after 2^LEN_W bytes.
        last_byte_s = (idx_inc_s == len_q[ch_q]);
        if ((state_q == WRITE) && last_byte_s) begin
            arb_req_s = others_s;
        end else begin
            arb_req_s = pending_q;
        end
    end

    core_dma_arbiter #(
        .CH_COUNT (CH_COUNT)
    ) u_arbiter (
        .req_i   (arb_req_s),
        .grant_o (grant_s),
        .valid_o (grant_valid_s)
    );

    // One-hot grant to channel index.
    always_comb begin
        grant_idx_s = '0;
        for (int i = 0; i < CH_COUNT; i++) begin
            grant_idx_s = grant_idx_s | (grant_s[i] ? CH_W'(i) : '0);
        end
    end

    // Bus-cycle FSM: next state, channel, index, acknowledge and read data.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        clear_s = '0;
        ack_d   = '0;
        data_d  = data_q;
        for (int i = 0; i < CH_COUNT; i++) begin
            idx_d[i] = idx_q[i];
        end
        if (I_tick) begin
            case (state_q)
                IDLE: begin
                    if (|pending_q) begin
                        state_d = HALT;
                    end else begin
                        state_d = IDLE;
                    end
                end
                HALT, ALIGN: begin
                    if (!I_sync) begin
                        state_d = ALIGN;
                    end else if (grant_valid_s) begin
                        state_d = READ;
                        ch_d    = grant_idx_s;
                    end else begin
                        state_d = IDLE;
                    end
                end
                READ: begin
                    data_d = I_data;
                    if (mode_q[ch_q] == MODE_SINGLE) begin
                        ack_d   = cur_oh_s;
                        clear_s = cur_oh_s;
                        state_d = (|others_s) ? ALIGN : IDLE;
                    end else begin
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    if (last_byte_s) begin
                        idx_d[ch_q] = '0;
                        ack_d       = cur_oh_s;
                        clear_s     = cur_oh_s;
                    end else begin
                        idx_d[ch_q] = idx_inc_s;
                    end
                    // Preemption point: a higher-priority pending channel takes the next READ.
                    if (grant_valid_s) begin
                        state_d = READ;
                        ch_d    = grant_idx_s;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        pending_d = (pending_q & ~clear_s) | capture_s;
    end

    // Bus address/direction and ready for the cycle being entered.
    always_comb begin
        case (state_d)
            READ: begin
                addr_d = src_q[ch_d] + 16'(idx_d[ch_d]);
                rdwr_d = 1'b1;
            end
            WRITE: begin
                addr_d = DST_ADDR;
                rdwr_d = 1'b0;
            end
            default: begin
                addr_d = IDLE_ADDR;
                rdwr_d = 1'b1;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    // State, per-channel context and registered bus outputs.
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ch_q      <= '0;
            addr_q    <= IDLE_ADDR;
            rdwr_q    <= 1'b1;
            data_q    <= 8'h00;
            ack_q     <= '0;
            ready_q   <= 1'b1;
            for (int i = 0; i < CH_COUNT; i++) begin
                src_q[i]  <= 16'h0000;
                len_q[i]  <= '0;
                mode_q[i] <= MODE_BLOCK;
                idx_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ch_q      <= ch_d;
            addr_q    <= addr_d;
            rdwr_q    <= rdwr_d;
            data_q    <= data_d;
            ack_q     <= ack_d;
            ready_q   <= ready_d;
            for (int i = 0; i < CH_COUNT; i++) begin
                idx_q[i] <= idx_d[i];
                if (capture_s[i]) begin
                    src_q[i]  <= I_src[i*16 +: 16];
                    len_q[i]  <= I_len[i*LEN_W +: LEN_W];
                    mode_q[i] <= dma_mode_e'(I_mode[i]);
                end
            end
        end
    end

    assign O_addr  = addr_q;
    assign O_rdwr  = rdwr_q;
    assign O_data  = data_q;
    assign O_ack   = ack_q;
    assign O_ready = ready_q;

endmodule

// File: tb/tb_core_dma_mc.sv
// Scoreboard bench for core_dma_mc: expected bus cycles and acknowledges are
// queued when a request is raised and compared tick by tick as the DMA runs.
module tb_core_dma_mc;

    localparam logic [15:0] DST = 16'h2004;

    logic        I_clock = 1'b0;
    logic        I_reset;
    logic        I_tick;
    logic        I_sync;
    logic [15:0] O_addr;
    logic        O_rdwr;
    logic [7:0]  I_data;
    logic [7:0]  O_data;
    logic [1:0]  I_req;
    logic [1:0]  I_mode;
    logic [31:0] I_src;
    logic [15:0] I_len;
    logic [1:0]  O_ack;
    logic        O_ready;

    typedef struct {
        logic [15:0] addr;
        logic        rdwr;
        logic        chk_data;
        logic [7:0]  data;
    } bus_t;

    typedef struct {
        logic [1:0] ack;
        logic       chk_data;
        logic [7:0] data;
    } ack_t;

    bus_t exp_q[$];
    ack_t ack_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   busy_ticks = 0;
    int   tick_ph    = 0;
    logic align_mode = 1'b0;

    core_dma_mc u_dut (
        .I_clock (I_clock),
        .I_reset (I_reset),
        .I_tick  (I_tick),
        .I_sync  (I_sync),
        .O_addr  (O_addr),
        .O_rdwr  (O_rdwr),
        .I_data  (I_data),
        .O_data  (O_data),
        .I_req   (I_req),
        .I_mode  (I_mode),
        .I_src   (I_src),
        .I_len   (I_len),
        .O_ack   (O_ack),
        .O_ready (O_ready)
    );

    always #5 I_clock = ~I_clock;

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        if (a == 16'hC000) return 8'h5A;
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    assign I_data = mem_rd(O_addr);

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_bus(input logic [15:0] a, input logic rw, input logic cd, input logic [7:0] d);
        bus_t e;
        e.addr = a; e.rdwr = rw; e.chk_data = cd; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_idle();
        push_bus(16'h0000, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic push_block(input logic [15:0] src, input int first, input int count);
        logic [15:0] a;
        for (int k = first; k < first + count; k++) begin
            a = src + 16'(k);
            push_bus(a, 1'b1, 1'b0, 8'h00);
            push_bus(DST, 1'b0, 1'b1, mem_rd(a));
        end
    endtask

    task automatic push_ack(input logic [1:0] v, input logic cd, input logic [7:0] d);
        ack_t e;
        e.ack = v; e.chk_data = cd; e.data = d;
        ack_q.push_back(e);
    endtask

    task automatic raise_req(input int ch, input logic mode, input logic [15:0] src, input logic [7:0] len);
        I_src[ch*16 +: 16] = src;
        I_len[ch*8 +: 8]   = len;
        I_mode[ch]         = mode;
        I_req[ch]          = 1'b1;
        @(posedge I_clock); #1;
        I_req[ch]          = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ack_q.size() != 0 || !O_ready) && n < budget) begin
            @(posedge I_clock);
            n++;
        end
        check_eq({tag, "_timeout"}, 32'(n < budget), 32'd1);
        #1;
    endtask

    task automatic wait_busy(input int target, input int budget);
        int n;
        n = 0;
        while (busy_ticks < target && n < budget) begin
            @(posedge I_clock);
            n++;
        end
        check_eq("busy_wait_timeout", 32'(n < budget), 32'd1);
    endtask

    // Tick enable on two of every three clocks; sync held low through HALT when asked.
    initial begin
        I_tick = 1'b0;
        I_sync = 1'b1;
        forever begin
            @(posedge I_clock); #1;
            tick_ph = (tick_ph + 1) % 3;
            I_tick  = (tick_ph != 2);
            I_sync  = !(align_mode && !O_ready && busy_ticks == 0);
        end
    end

    // Monitor: one expected bus cycle per non-idle tick, one entry per acknowledge pulse.
    always @(negedge I_clock) begin
        if (I_reset && I_tick && !O_ready) begin
            busy_ticks = busy_ticks + 1;
            if (exp_q.size() == 0) begin
                check_eq("bus_extra", 32'(exp_q.size()), 32'd1);
            end else begin
                bus_t e;
                e = exp_q.pop_front();
                check_eq("bus_addr", 32'(O_addr), 32'(e.addr));
                check_eq("bus_rdwr", 32'(O_rdwr), 32'(e.rdwr));
                if (e.chk_data) check_eq("bus_wdata", 32'(O_data), 32'(e.data));
            end
        end
        if (O_ack != 2'b00) begin
            if (ack_q.size() == 0) begin
                check_eq("ack_extra", 32'(O_ack), 32'd0);
            end else begin
                ack_t a;
                a = ack_q.pop_front();
                check_eq("ack_vec", 32'(O_ack), 32'(a.ack));
                if (a.chk_data) check_eq("ack_data", 32'(O_data), 32'(a.data));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        I_reset = 1'b0;
        I_req   = 2'b00;
        I_mode  = 2'b00;
        I_src   = 32'h0000_0000;
        I_len   = 16'h0000;
        // Requests raised during reset must be discarded.
        repeat (2) @(posedge I_clock);
        #1 I_req = 2'b11;
        @(posedge I_clock); #1;
        check_eq("rst_addr",  32'(O_addr),  32'h0000);
        check_eq("rst_rdwr",  32'(O_rdwr),  32'd1);
        check_eq("rst_data",  32'(O_data),  32'h00);
        check_eq("rst_ack",   32'(O_ack),   32'd0);
        check_eq("rst_ready", 32'(O_ready), 32'd1);
        I_req = 2'b00;
        @(posedge I_clock); #1 I_reset = 1'b1;
        repeat (12) @(posedge I_clock);
        #1;
        check_eq("rst_discard_busy",  32'(busy_ticks), 32'd0);
        check_eq("rst_discard_ready", 32'(O_ready),    32'd1);

        // Ch0 block, len 0 (256 bytes), sync high at HALT.
        busy_ticks = 0; align_mode = 1'b0;
        push_idle();
        push_block(16'h0200, 0, 256);
        push_ack(2'b01, 1'b0, 8'h00);
        raise_req(0, 1'b0, 16'h0200, 8'h00);
        wait_done("blk256", 3000);
        check_eq("blk256_ticks", 32'(busy_ticks), 32'd513);
        check_eq("blk256_ready", 32'(O_ready),    32'd1);

        // Same block with sync low at HALT: one ALIGN tick.
        busy_ticks = 0; align_mode = 1'b1;
        push_idle();
        push_idle();
        push_block(16'h0200, 0, 256);
        push_ack(2'b01, 1'b0, 8'h00);
        raise_req(0, 1'b0, 16'h0200, 8'h00);
        wait_done("blk256_align", 3000);
        check_eq("blk256_align_ticks", 32'(busy_ticks), 32'd514);
        align_mode = 1'b0;

        // Ch1 single fetch from C000.
        busy_ticks = 0;
        push_idle();
        push_bus(16'hC000, 1'b1, 1'b0, 8'h00);
        push_ack(2'b10, 1'b1, 8'h5A);
        raise_req(1, 1'b1, 16'hC000, 8'h00);
        wait_done("single", 200);
        check_eq("single_ticks", 32'(busy_ticks), 32'd2);
        check_eq("single_data",  32'(O_data),     32'h5A);

        // Ch1 block len 4 preempted by ch0 single, resumed at byte 2.
        busy_ticks = 0;
        push_idle();
        push_block(16'h1000, 0, 2);
        push_bus(16'h3000, 1'b1, 1'b0, 8'h00);
        push_idle();
        push_block(16'h1000, 2, 2);
        push_ack(2'b01, 1'b1, mem_rd(16'h3000));
        push_ack(2'b10, 1'b0, 8'h00);
        raise_req(1, 1'b0, 16'h1000, 8'd4);
        wait_busy(3, 200);
        #1;
        raise_req(0, 1'b1, 16'h3000, 8'h00);
        wait_done("preempt", 300);
        check_eq("preempt_ticks", 32'(busy_ticks), 32'd11);

        // Source address wrap across FFFF.
        busy_ticks = 0;
        push_idle();
        push_block(16'hFFFE, 0, 4);
        push_ack(2'b01, 1'b0, 8'h00);
        raise_req(0, 1'b0, 16'hFFFE, 8'd4);
        wait_done("wrap", 300);
        check_eq("wrap_ticks", 32'(busy_ticks), 32'd9);

        // Reset asserted during the first WRITE of a block.
        busy_ticks = 0;
        push_idle();
        push_bus(16'h0400, 1'b1, 1'b0, 8'h00);
        raise_req(0, 1'b0, 16'h0400, 8'd8);
        wait_busy(2, 200);
        #2;
        check_eq("pre_rst_rdwr", 32'(O_rdwr), 32'd0);
        I_reset = 1'b0;
        #1;
        check_eq("midrst_rdwr",  32'(O_rdwr),  32'd1);
        check_eq("midrst_ready", 32'(O_ready), 32'd1);
        check_eq("midrst_addr",  32'(O_addr),  32'h0000);
        I_req = 2'b10;
        repeat (2) @(posedge I_clock);
        #1 I_req = 2'b00;
        @(posedge I_clock); #1 I_reset = 1'b1;
        repeat (30) @(posedge I_clock);
        #1;
        check_eq("postrst_busy",  32'(busy_ticks),    32'd2);
        check_eq("postrst_ready", 32'(O_ready),       32'd1);
        check_eq("postrst_queue", 32'(exp_q.size()),  32'd0);
        check_eq("postrst_acks",  32'(ack_q.size()),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
